periph_bus_initiator: RTL



---
 rtl/periph_bus_initiator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/periph_bus_initiator.sv
// Single-outstanding peripheral register bus initiator.
// Executes read, write and masked-compare poll commands, one response each.
module periph_bus_initiator #(
  parameter int POLL_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [31:0]           cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  input  logic [31:0]           cmd_mask_i,
  input  logic [POLL_CNT_W-1:0] cmd_timeout_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [POLL_CNT_W-1:0] rsp_count_o,
  output logic [31:0]           bus_addr_o,
  output logic [31:0]           bus_data_o,
  output logic                  bus_we_o,
  input  logic [31:0]           bus_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    POLL,
    RESP
  } state_e;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_PL = 2'b10;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           mask_q, mask_d;
  logic [POLL_CNT_W-1:0] tmo_q, tmo_d;
  logic [POLL_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  cmd_ready;
  logic                  rsp_valid;
  logic [31:0]           bus_addr;
  logic [31:0]           bus_data;
  logic                  bus_we;
  logic                  match;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign match = ((bus_data_i ^ wdata_q) & mask_q) == 32'h0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_addr  = '0;
    bus_data  = '0;
    bus_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          mask_d  = cmd_mask_i;
          tmo_d   = cmd_timeout_i;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          unique case (cmd_op_i)
            OP_RD,
            OP_WR:   state_d = ACCESS;
            OP_PL:   state_d = POLL;
            default: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ACCESS: begin
        bus_addr = addr_q;
        if (op_q == OP_WR) begin
          bus_we   = 1'b1;
          bus_data = wdata_q;
          rdata_d  = '0;
        end else begin
          rdata_d  = bus_data_i;
        end
        err_d   = 1'b0;
        state_d = RESP;
      end
      POLL: begin
        bus_addr = addr_q;
        // Match wins even on the last allowed read.
        if (match) begin
          rdata_d = bus_data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == tmo_q) begin
          rdata_d = bus_data_i;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every output low, even before the first edge.
  assign cmd_ready_o = cmd_ready & ~rst_i;
  assign rsp_valid_o = rsp_valid & ~rst_i;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_count_o = rsp_valid_o ? cnt_q : '0;
  assign bus_addr_o  = rst_i ? '0 : bus_addr;
  assign bus_data_o  = rst_i ? '0 : bus_data;
  assign bus_we_o    = bus_we & ~rst_i;

endmodule
